// File: rtl/cache_miss_sequencer.sv
// cache_miss_sequencer: miss handling for a set-associative cache.
// On a miss it picks a victim way, optionally writes the dirty victim line
// back, refills the line beat by beat from memory, writes the new tag and
// completes with a four-phase miss_req/miss_ack handshake.
// Macro CACHE_SEQ_WRITEBACK_EN: defined -> write-back cache (WB state compiled);
// undefined -> write-through cache (way_dirty ignored, every miss is clean).
module cache_miss_sequencer #(
  parameter int WAYS            = 4,
  parameter int INDEX_BITS      = 8,
  parameter int TAG_BITS        = 18,
  parameter int OFFSET_BITS     = 6,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  localparam int BEATS          = LINE_SIZE_BYTES * 8 / DATA_WIDTH,
  localparam int WAY_BITS       = $clog2(WAYS),
  localparam int BEAT_BITS      = $clog2(BEATS),
  localparam int BYTE_BITS      = OFFSET_BITS - BEAT_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_req,
  input  logic [ADDRESS_WIDTH-1:0] miss_addr,
  output logic                     miss_ack,
  output logic                     busy,
  input  logic [WAYS-1:0]          way_valid,
  input  logic [WAYS-1:0]          way_dirty,
  input  logic [WAY_BITS-1:0]      lru_way,
  input  logic [TAG_BITS-1:0]      sel_tag,
  output logic [WAY_BITS-1:0]      arr_way,
  output logic [INDEX_BITS-1:0]    arr_index,
  output logic [BEAT_BITS-1:0]     arr_beat,
  input  logic [DATA_WIDTH-1:0]    arr_rdata,
  output logic                     arr_we,
  output logic [DATA_WIDTH-1:0]    arr_wdata,
  output logic                     arr_tag_we,
  output logic [TAG_BITS-1:0]      arr_tag,
  output logic                     lru_touch,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
`ifdef CACHE_SEQ_WRITEBACK_EN
    WB,
`endif
    FILL,
    UPDATE,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [WAY_BITS-1:0]    way_q, way_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [INDEX_BITS-1:0]  index_q, index_d;
  logic [WAY_BITS-1:0]    victim;
  logic                   busy_q, miss_ack_q, mem_req_q, update_q;
  logic                   beat_done, last_beat;
  logic [TAG_BITS-1:0]    addr_tag;

  // Victim choice: lowest-index invalid way, otherwise the LRU way.
  always_comb begin
    victim = lru_way;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) victim = WAY_BITS'(i);
    end
  end

  assign beat_done = mem_req_q & mem_ready;
  assign last_beat = (beat_q == BEAT_BITS'(BEATS - 1));

  // Next-state, beat counter and latched miss context.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    beat_d  = beat_q;
    way_d   = way_q;
    tag_d   = tag_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (miss_req) begin
          tag_d   = miss_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
          index_d = miss_addr[OFFSET_BITS +: INDEX_BITS];
          state_d = SELECT;
        end
      end
      SELECT: begin
        way_d   = victim;
        beat_d  = '0;
        state_d = FILL;
`ifdef CACHE_SEQ_WRITEBACK_EN
        if (way_valid[victim] && way_dirty[victim]) state_d = WB;
`endif
      end
`ifdef CACHE_SEQ_WRITEBACK_EN
      WB: begin
        if (beat_done) begin
          beat_d = beat_q + 1'b1;  // wraps to 0 after the last beat
          if (last_beat) state_d = FILL;
        end
      end
`endif
      FILL: begin
        if (beat_done) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = UPDATE;
        end
      end
      UPDATE:  state_d = DONE;
      DONE:    if (!miss_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, context and registered control outputs; reset abandons any beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      index_q    <= '0;
      busy_q     <= 1'b0;
      miss_ack_q <= 1'b0;
      mem_req_q  <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      beat_q     <= beat_d;
      way_q      <= way_d;
      tag_q      <= tag_d;
      index_q    <= index_d;
      busy_q     <= (state_d != IDLE);
      miss_ack_q <= (state_d == DONE);
`ifdef CACHE_SEQ_WRITEBACK_EN
      mem_req_q  <= (state_d == FILL) || (state_d == WB);
`else
      mem_req_q  <= (state_d == FILL);
`endif
      update_q   <= (state_d == UPDATE);
    end
  end

`ifdef CACHE_SEQ_WRITEBACK_EN
  logic mem_we_q;

  // Write direction flag, high for the whole write-back phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_we_q <= 1'b0;
    else     mem_we_q <= (state_d == WB);
  end

  assign mem_we    = mem_we_q;
  assign addr_tag  = mem_we_q ? sel_tag : tag_q;
  assign mem_wdata = mem_we_q ? arr_rdata : '0;
`else
  logic unused_wb_inputs;
  assign unused_wb_inputs = ^{way_dirty, sel_tag, arr_rdata};
  assign mem_we    = 1'b0;
  assign addr_tag  = tag_q;
  assign mem_wdata = '0;
`endif

  logic unused_offset;
  assign unused_offset = ^miss_addr[OFFSET_BITS-1:0];

  // Bus address is held constant by beat_q while a beat is stalled.
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_req_q ? {addr_tag, index_q, beat_q, {BYTE_BITS{1'b0}}} : '0;
  assign arr_we     = mem_req_q & ~mem_we & mem_ready;
  assign arr_wdata  = (mem_req_q & ~mem_we) ? mem_rdata : '0;
  assign arr_way    = way_q;
  assign arr_index  = index_q;
  assign arr_beat   = beat_q;
  assign arr_tag    = tag_q;
  assign arr_tag_we = update_q;
  assign lru_touch  = update_q;
  assign busy       = busy_q;
  assign miss_ack   = miss_ack_q;

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed testbench for cache_miss_sequencer. Expected values are computed
// from the line address arithmetic; build with or without CACHE_SEQ_WRITEBACK_EN.
module tb_cache_miss_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_ack, busy;
  logic [3:0]  way_valid, way_dirty;
  logic [1:0]  lru_way;
  logic [17:0] sel_tag;
  logic [1:0]  arr_way;
  logic [7:0]  arr_index;
  logic [3:0]  arr_beat;
  logic [31:0] arr_rdata;
  logic        arr_we;
  logic [31:0] arr_wdata;
  logic        arr_tag_we;
  logic [17:0] arr_tag;
  logic        lru_touch;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RD_KEY = 32'h5A5A_A5A5;

  cache_miss_sequencer dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ack(miss_ack), .busy(busy), .way_valid(way_valid), .way_dirty(way_dirty),
    .lru_way(lru_way), .sel_tag(sel_tag), .arr_way(arr_way), .arr_index(arr_index),
    .arr_beat(arr_beat), .arr_rdata(arr_rdata), .arr_we(arr_we), .arr_wdata(arr_wdata),
    .arr_tag_we(arr_tag_we), .arr_tag(arr_tag), .lru_touch(lru_touch),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Array and memory models: read data is a fixed function of the address.
  assign arr_rdata = {16'hD0D0, 6'b0, arr_way, 4'h0, arr_beat};
  assign mem_rdata = mem_addr ^ RD_KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one miss to completion, checking every bus beat and the pulse counts.
  task automatic run_miss(input logic [31:0] addr, input logic [3:0] valid,
                          input logic [3:0] dirty, input logic [1:0] lru,
                          input logic [17:0] stag, input bit use_pat,
                          input logic [1:0] exp_way, input int exp_wb,
                          input int exp_ack, input int hold);
    logic [31:0] line_base, wb_base;
    logic [3:0]  pat;
    int cyc, fills, wbs, tagwes, lrus, pi;
    bit got_ack;
    line_base = {addr[31:6], 6'b0};
    wb_base   = {stag, addr[13:6], 6'b0};
    pat = 4'b1001;  // ready pattern 1,0,0,1 read from bit 3 down
    cyc = 0; fills = 0; wbs = 0; tagwes = 0; lrus = 0; pi = 0; got_ack = 0;
    @(negedge clk);
    miss_addr = addr; way_valid = valid; way_dirty = dirty; lru_way = lru;
    sel_tag = stag; miss_req = 1'b1; mem_ready = 1'b1;
    while (!got_ack && cyc < 300) begin
      if (use_pat && mem_req && !mem_we) begin
        mem_ready = pat[3 - (pi % 4)];
        pi++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (miss_ack) begin
        got_ack = 1;
        chk("ack_cycle", cyc, exp_ack);
      end
      if (mem_req) begin
        chk("arr_way_hold", arr_way, exp_way);
        if (mem_we) begin
          chk("wb_addr", mem_addr, wb_base + 32'(wbs * 4));
          chk("wb_data", mem_wdata, {16'hD0D0, 6'b0, exp_way, 4'h0, 4'(wbs)});
          if (mem_ready) wbs++;
        end else begin
          chk("fill_addr", mem_addr, line_base + 32'(fills * 4));
          chk("fill_we", arr_we, mem_ready);
          if (arr_we) begin
            chk("fill_data", arr_wdata, (line_base + 32'(fills * 4)) ^ RD_KEY);
            fills++;
          end
        end
      end else begin
        chk("idle_we", arr_we, 1'b0);
      end
      if (arr_tag_we) begin
        tagwes++;
        chk("tag_value", arr_tag, addr[31:14]);
        chk("tag_way", arr_way, exp_way);
        chk("tag_index", arr_index, addr[13:6]);
      end
      if (lru_touch) lrus++;
      if (!got_ack) begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready = 1'b1;
    chk("ack_seen", got_ack, 1'b1);
    chk("fill_count", fills, 16);
    chk("wb_count", wbs, exp_wb);
    chk("tag_we_count", tagwes, 1);
    chk("lru_count", lrus, 1);
    chk("busy_in_done", busy, 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk("ack_held", miss_ack, 1'b1);
      chk("no_retrigger", {busy, mem_req, arr_tag_we}, 3'b100);
    end
    miss_req = 1'b0;
    @(negedge clk); #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_ack", miss_ack, 1'b0);
  endtask

  initial begin
    int n;
    int tw;
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; way_valid = '0; way_dirty = '0;
    lru_way = '0; sel_tag = '0; mem_ready = 1'b1;
    #1;
    // Reset state: every output low.
    chk("rst_ctrl", {miss_ack, busy, arr_we, arr_tag_we, lru_touch, mem_req, mem_we}, 7'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_arr", {arr_way, arr_index, arr_beat}, 14'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Clean miss into the first invalid way (2); miss_req held 3 cycles past ack.
    run_miss(32'h0001_2340, 4'b0011, 4'b0000, 2'd0, 18'h0, 1'b0, 2'd2, 0, 19, 3);

    // All ways valid, LRU way 3 dirty.
`ifdef CACHE_SEQ_WRITEBACK_EN
    run_miss(32'h0ABC_D000, 4'b1111, 4'b1000, 2'd3, 18'h2AAAA, 1'b0, 2'd3, 16, 35, 0);
`else
    run_miss(32'h0ABC_D000, 4'b1111, 4'b1000, 2'd3, 18'h2AAAA, 1'b0, 2'd3, 0, 19, 0);
`endif

    // All valid, LRU way 1 clean: no write-back in either build.
    run_miss(32'hFFFF_FFC4, 4'b1111, 4'b1000, 2'd1, 18'h2AAAA, 1'b0, 2'd1, 0, 19, 0);

    // Ready pattern 1,0,0,1 during fill: 16 stall cycles, ack at 19 + 16.
    run_miss(32'h0001_2340, 4'b1110, 4'b0000, 2'd2, 18'h0, 1'b1, 2'd0, 0, 35, 1);

    // Reset in FILL after beat 5 completes.
    n = 0; tw = 0;
    @(negedge clk);
    miss_addr = 32'h0001_2340; way_valid = 4'b0011; way_dirty = 4'b0; miss_req = 1'b1;
    mem_ready = 1'b1;
    repeat (8) begin
      #1;
      if (arr_we) n++;
      if (arr_tag_we) tw++;
      @(negedge clk);
    end
    chk("pre_rst_beats", n, 6);
    chk("pre_rst_fill", {mem_req, mem_we, arr_beat}, {2'b10, 4'd6});
    rst = 1'b1; miss_req = 1'b0;
    #1;
    chk("mid_rst_ctrl", {miss_ack, busy, arr_we, arr_tag_we, lru_touch, mem_req, mem_we}, 7'b0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_data", arr_wdata, 32'h0);
    chk("mid_rst_beat", {arr_way, arr_index, arr_beat}, 14'h0);
    chk("mid_rst_no_tag", tw, 0);
    @(negedge clk);
    rst = 1'b0;

    // A new miss restarts from beat 0.
    run_miss(32'h0001_2340, 4'b0011, 4'b0000, 2'd0, 18'h0, 1'b0, 2'd2, 0, 19, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
